multiport_register_file: RTL and testbench
==========================================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and datapath width.
REQ-002 SHALL have parameter ADDR_W, default 3, register index width; NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rd_addr, input, NUM_RD*ADDR_W, packed read indices; port i uses slice i.
REQ-008 SHALL have port rd_data, output, NUM_RD*DATA_W, packed read data.
REQ-009 SHALL have port rd_hazard, output, NUM_RD, per-port: operand pending, not yet valid.
REQ-010 SHALL have port issue_valid, input, 1, request to reserve a destination register.
REQ-011 SHALL have port issue_dst, input, ADDR_W, destination to reserve.
REQ-012 SHALL have port issue_ready, output, 1, reservation accepted this cycle.
REQ-013 SHALL have port wb_en, input, 1, write-back strobe.
REQ-014 SHALL have port wb_addr, input, ADDR_W, write-back destination.
REQ-015 SHALL have port wb_sel, input, 2, source: 00 mem_out, 01 alu_out, 10 pc+1, 11 reserved.
REQ-016 SHALL have ports mem_out, alu_out, pc, each input, DATA_W, write-back sources.

Function
REQ-017 Write-back data SHALL be selected per wb_sel; pc+1 computed modulo 2**DATA_W (0xFFFF+1 = 0x0000).
REQ-018 wb_sel = 11 SHALL suppress the write and SHALL still clear the busy bit of wb_addr.
REQ-019 Register write SHALL occur on posedge clk when wb_en=1 and wb_sel!=11, except index 0 when ZERO_REG=1.
REQ-020 Reads SHALL be combinational; a read of the address being written that cycle SHALL return the write-back data (bypass), not the stale value.
REQ-021 Index 0 with ZERO_REG=1 SHALL always read 0, never busy, never bypassed.
REQ-022 A scoreboard SHALL hold one busy bit per register; issue_valid & issue_ready sets busy[issue_dst] next cycle; wb_en clears busy[wb_addr] next cycle.
REQ-023 issue_ready SHALL be combinational: 1 unless busy[issue_dst]=1 and not cleared by a same-cycle write-back to issue_dst (WAW stall).
REQ-024 Simultaneous accepted issue and write-back to the same register SHALL leave it busy (new reservation wins).
REQ-025 Issue to index 0 with ZERO_REG=1 SHALL be accepted and SHALL NOT set busy.
REQ-026 rd_hazard[i] SHALL equal busy[rd_addr_i] AND NOT (wb_en AND wb_addr==rd_addr_i).
REQ-027 Any number of read ports SHALL access the same index simultaneously with identical results.

Reset
REQ-028 While rst=1 at posedge clk, all registers SHALL clear to 0 and all busy bits to 0; writes and issues that cycle SHALL be ignored.
REQ-029 After reset, issue_ready SHALL be 1 and rd_hazard all 0 for any address.

Structure
REQ-030 wb_sel encodings WB_MEM, WB_ALU, WB_PC1, WB_NONE SHALL live in shared package cpu_pkg, reused by the control unit.
REQ-031 Busy-bit logic SHALL be a sub-module regfile_scoreboard (parameters ADDR_W, NUM_RD, ZERO_REG).

Verification
REQ-032 Reset, then wb_en, wb_addr=3, wb_sel=01, alu_out=0x1234 -> same cycle rd_data[port0 @3]=0x1234 (bypass); next cycle still 0x1234.
REQ-033 wb_addr=0, wb_sel=00, mem_out=0xBEEF, ZERO_REG=1 -> rd_data @0 stays 0x0000.
REQ-034 issue_dst=5 accepted; next cycle issue_dst=5 -> issue_ready=0, rd_hazard @5=1; wb_en to 5 same cycle -> issue_ready=1, rd_hazard=0.
REQ-035 wb_sel=10, pc=0xFFFF to reg 2 -> reg 2 = 0x0000; wb_sel=11 to busy reg 4 -> value unchanged, busy cleared.
REQ-036 busy regs 1,6 and reg 1=0x00AA; assert rst with concurrent wb_en -> next cycle all reads 0, no hazards, issue_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back source encodings used by the register file
// and the control unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        WB_MEM  = 2'b00,
        WB_ALU  = 2'b01,
        WB_PC1  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

endpackage : cpu_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking outstanding destination reservations, with
// issue back-pressure (WAW stall) and per-read-port operand hazard flags.
module regfile_scoreboard #(
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_hazard,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_dst,
    output logic                     issue_ready,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             dst_is_zero;

    // A write-back landing on the destination this cycle frees it in time.
    assign issue_ready = !busy_q[issue_dst] || (wb_en && (wb_addr == issue_dst));
    assign dst_is_zero = (ZERO_REG != 0) && (issue_dst == '0);

    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle new reservation wins.
        if (issue_valid && issue_ready && !dst_is_zero) begin
            busy_d[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        rd_hazard = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a            = rd_addr[i*ADDR_W +: ADDR_W];
            rd_hazard[i] = busy_q[a] && !(wb_en && (wb_addr == a));
        end
    end

endmodule : regfile_scoreboard

// File: rtl/multiport_register_file.sv
// Multi-read-port register file with write-back source mux, same-cycle
// write bypass and a busy-bit scoreboard for operand/WAW hazards.
module multiport_register_file
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_hazard,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_dst,
    output logic                     issue_ready,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [1:0]               wb_sel,
    input  logic [DATA_W-1:0]        mem_out,
    input  logic [DATA_W-1:0]        alu_out,
    input  logic [DATA_W-1:0]        pc
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] wb_data;
    logic              wb_write;

    always_comb begin
        case (wb_sel_e'(wb_sel))
            WB_MEM:  wb_data = mem_out;
            WB_ALU:  wb_data = alu_out;
            WB_PC1:  wb_data = pc + DATA_W'(1);
            default: wb_data = '0;
        endcase
    end

    // Reset-cycle writes are dropped, so they must not be bypassed either.
    assign wb_write = wb_en && !rst && (wb_sel_e'(wb_sel) != WB_NONE)
                      && !((ZERO_REG != 0) && (wb_addr == '0));

    always_comb begin
        regs_d = regs_q;
        if (wb_write) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a = rd_addr[i*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (a == '0)) begin
                v = '0;
            end else if (wb_write && (wb_addr == a)) begin
                v = wb_data;
            end else begin
                v = regs_q[a];
            end
            rd_data[i*DATA_W +: DATA_W] = v;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_hazard   (rd_hazard),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .issue_ready (issue_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr)
    );

endmodule : multiport_register_file

// File: tb/tb_multiport_register_file.sv
// Directed and randomized checks of multiport_register_file against an
// array-based behavioural model of register contents and reservations.
module tb_multiport_register_file;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 2;
    localparam int N  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_hazard;
    logic             issue_valid;
    logic [AW-1:0]    issue_dst;
    logic             issue_ready;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [1:0]       wb_sel;
    logic [DW-1:0]    mem_out;
    logic [DW-1:0]    alu_out;
    logic [DW-1:0]    pc;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_reg  [N];
    bit            m_busy [N];

    multiport_register_file #(
        .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .ZERO_REG (1)
    ) dut (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data),
        .rd_hazard (rd_hazard), .issue_valid (issue_valid), .issue_dst (issue_dst),
        .issue_ready (issue_ready), .wb_en (wb_en), .wb_addr (wb_addr),
        .wb_sel (wb_sel), .mem_out (mem_out), .alu_out (alu_out), .pc (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] wb_value();
        logic [DW-1:0] one;
        one = 1;
        case (wb_sel)
            2'd0:    return mem_out;
            2'd1:    return alu_out;
            2'd2:    return pc + one;
            default: return '0;
        endcase
    endfunction

    function automatic bit wb_writes();
        return wb_en && !rst && (wb_sel != 2'd3) && (wb_addr != 0);
    endfunction

    function automatic bit wb_frees(input logic [AW-1:0] a);
        return wb_en && (wb_addr == a);
    endfunction

    task automatic check_outputs();
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        for (int i = 0; i < NR; i++) begin
            a = rd_addr[i*AW +: AW];
            if (a == 0)                            e = '0;
            else if (wb_writes() && wb_addr == a) e = wb_value();
            else                                   e = m_reg[a];
            chk($sformatf("rd_data[%0d]@%0d", i, a), rd_data[i*DW +: DW], e);
            chk($sformatf("rd_hazard[%0d]@%0d", i, a), rd_hazard[i],
                m_busy[a] && !wb_frees(a));
        end
        chk($sformatf("issue_ready@%0d", issue_dst), issue_ready,
            !(m_busy[issue_dst] && !wb_frees(issue_dst)));
    endtask

    // Inputs are stable from posedge+1; check mid-cycle, then commit the model.
    task automatic tick();
        bit ready;
        #3;
        if (!rst) check_outputs();
        ready = !(m_busy[issue_dst] && !wb_frees(issue_dst));
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                m_reg[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (wb_writes()) m_reg[wb_addr] = wb_value();
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (issue_valid && ready && issue_dst != 0) m_busy[issue_dst] = 1'b1;
        end
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; issue_valid = 0; issue_dst = '0; wb_en = 0;
        wb_addr = '0; wb_sel = 2'd0; mem_out = '0; alu_out = '0; pc = '0;
        for (int r = 0; r < N; r++) begin m_reg[r] = '0; m_busy[r] = 0; end
        tick(); tick();
        rst = 1'b0;

        // Post-reset idle state over every address
        for (int a = 0; a < N; a++) begin
            set_rd(a, N - 1 - a); issue_dst = AW'(a);
            tick();
        end

        // Bypass on write, then registered value
        wb_en = 1; wb_addr = 3; wb_sel = 2'd1; alu_out = 16'h1234; set_rd(3, 3);
        #2; chk("bypass_r3", rd_data[DW-1:0], 16'h1234);
        tick();
        wb_en = 0;
        #2; chk("held_r3", rd_data[DW-1:0], 16'h1234);
        tick();

        // Writes to register 0 are discarded
        wb_en = 1; wb_addr = 0; wb_sel = 2'd0; mem_out = 16'hBEEF; set_rd(0, 3);
        #2; chk("zero_bypass", rd_data[DW-1:0], 16'h0000);
        tick();
        wb_en = 0;
        #2; chk("zero_held", rd_data[DW-1:0], 16'h0000);
        tick();

        // WAW stall on 5, released by same-cycle write-back; reissue keeps busy
        issue_valid = 1; issue_dst = 5; set_rd(5, 5);
        tick();
        #2; chk("waw_stall", issue_ready, 0); chk("hazard_5", rd_hazard[0], 1);
        wb_en = 1; wb_addr = 5; wb_sel = 2'd1; alu_out = 16'h0055;
        #1; chk("waw_release", issue_ready, 1); chk("hazard_5_clr", rd_hazard[0], 0);
        tick();
        issue_valid = 0; wb_en = 0;
        #2; chk("reissue_busy", rd_hazard[0], 1); chk("r5_value", rd_data[DW-1:0], 16'h0055);
        tick();
        wb_en = 1; wb_addr = 5; wb_sel = 2'd0; mem_out = 16'h5A5A;
        tick();
        wb_en = 0;
        tick();

        // pc+1 wraps; reserved select clears busy without writing
        wb_en = 1; wb_addr = 2; wb_sel = 2'd1; alu_out = 16'h7777; tick();
        wb_sel = 2'd2; pc = 16'hFFFF; tick();
        wb_en = 0; set_rd(2, 4);
        #2; chk("pc1_wrap", rd_data[DW-1:0], 16'h0000);
        wb_en = 1; wb_addr = 4; wb_sel = 2'd0; mem_out = 16'h4444; tick();
        wb_en = 0; issue_valid = 1; issue_dst = 4; tick();
        issue_valid = 0; wb_en = 1; wb_addr = 4; wb_sel = 2'd3; mem_out = 16'h9999; tick();
        wb_en = 0;
        #2; chk("r4_kept", rd_data[2*DW-1:DW], 16'h4444); chk("r4_free", rd_hazard[1], 0);
        tick();

        // Reset with pending state and concurrent write/issue
        issue_valid = 1; issue_dst = 1; tick();
        issue_dst = 6; tick();
        issue_valid = 0; wb_en = 1; wb_addr = 1; wb_sel = 2'd1; alu_out = 16'h00AA; tick();
        wb_en = 0; issue_valid = 1; issue_dst = 1; tick();
        issue_valid = 0; set_rd(6, 6);
        #2; chk("busy_6", rd_hazard[0], 1);
        tick();
        rst = 1; wb_en = 1; wb_addr = 1; alu_out = 16'h1111; issue_valid = 1; issue_dst = 3;
        tick();
        rst = 0; wb_en = 0; issue_valid = 0;
        for (int a = 0; a < N; a++) begin
            set_rd(a, a); issue_dst = AW'(a);
            #1; chk("rst_data", rd_data[DW-1:0], 0); chk("rst_haz", rd_hazard, 0);
            chk("rst_ready", issue_ready, 1);
            tick();
        end

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 59) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_dst   = AW'($urandom);
            wb_en       = ($urandom_range(0, 2) != 0);
            wb_addr     = ($urandom_range(0, 1) != 0) ? issue_dst : AW'($urandom);
            wb_sel      = 2'($urandom);
            mem_out     = DW'($urandom);
            alu_out     = DW'($urandom);
            pc          = ($urandom_range(0, 7) == 0) ? 16'hFFFF : DW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rd_addr = {2{AW'($urandom)}};
            end else begin
                rd_addr = (NR*AW)'($urandom);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multiport_register_file
